// File: rtl/data_ram_resp_pkg.sv
// Shared constants and types for the data RAM responder.
// Holds the register width, the zero word, and the default geometry of the RAM.
package data_ram_resp_pkg;

    localparam int unsigned REG_W          = 64;
    localparam logic [63:0] ZERO_WORD      = 64'h0;
    localparam int unsigned RAM_DEPTH_LOG2 = 8;
    localparam logic [63:0] RAM_BASE_ADDR  = 64'h0000_0000_8000_0000;

    typedef enum logic {
        StClear,
        StReady
    } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// Word-addressed storage array with a bit-masked write port and an async read port.
// The read returns the pre-edge contents, so a same-cycle read sees the old word.
module ram_array
    import data_ram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RAM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [REG_W-1:0]      wmask_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [REG_W-1:0]      rdata_o
);

    logic [REG_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_ram_resp.sv
// Data RAM responder: clears its array after reset, then services masked writes
// and combinational reads, tracking saturating access counts and a sticky error.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RAM_DEPTH_LOG2,
    parameter logic [63:0] BASE_ADDR  = RAM_BASE_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ram_addr,
    input  logic             ram_r_ena,
    input  logic             ram_w_ena,
    input  logic [REG_W-1:0] ram_w_mask,
    input  logic [REG_W-1:0] ram_w_data,
    output logic [REG_W-1:0] ram_r_data,
    output logic             ram_busy,
    output logic             ram_err,
    output logic [31:0]      rd_cnt,
    output logic [31:0]      wr_cnt
);

    localparam logic [63:0] ENTRIES = 64'd1 << DEPTH_LOG2;

    ram_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
    logic                  err_q, err_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;

    logic [63:0]           offset;
    logic [DEPTH_LOG2-1:0] index;
    logic                  in_range;
    logic                  ready;
    logic                  rd_svc;
    logic                  wr_svc;

    logic                  arr_we;
    logic [DEPTH_LOG2-1:0] arr_waddr;
    logic [REG_W-1:0]      arr_wmask;
    logic [REG_W-1:0]      arr_wdata;
    logic [REG_W-1:0]      arr_rdata;

    // Offset wraps, so addresses below BASE_ADDR land far out of range.
    assign offset   = ram_addr - BASE_ADDR;
    assign index    = offset[DEPTH_LOG2+2:3];
    assign in_range = (offset >> 3) < ENTRIES;
    assign ready    = (state_q == StReady);
    assign rd_svc   = ready && ram_r_ena && in_range;
    assign wr_svc   = ready && ram_w_ena && in_range;

    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = index;
        arr_wmask = ram_w_mask;
        arr_wdata = ram_w_data;
        if (!rst) begin
            if (state_q == StClear) begin
                arr_we    = 1'b1;
                arr_waddr = clr_idx_q;
                arr_wmask = '1;
                arr_wdata = ZERO_WORD;
            end else begin
                arr_we = wr_svc;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == StClear) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == {DEPTH_LOG2{1'b1}}) begin
                state_d = StReady;
            end
        end

        err_d = err_q || ((ram_r_ena || ram_w_ena) && !(ready && in_range));

        rd_cnt_d = (rd_svc && (rd_cnt_q != 32'hFFFF_FFFF)) ? rd_cnt_q + 32'd1 : rd_cnt_q;
        wr_cnt_d = (wr_svc && (wr_cnt_q != 32'hFFFF_FFFF)) ? wr_cnt_q + 32'd1 : wr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    ram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wmask_i (arr_wmask),
        .wdata_i (arr_wdata),
        .raddr_i (index),
        .rdata_o (arr_rdata)
    );

    assign ram_r_data = rd_svc ? arr_rdata : ZERO_WORD;
    assign ram_busy   = (state_q == StClear);
    assign ram_err    = err_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: stimulus queues expected read words, a
// negedge monitor pops and compares them whenever a serviced read is presented.
module tb_data_ram_resp;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        string       name;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ram_addr;
    logic        ram_r_ena;
    logic        ram_w_ena;
    logic [63:0] ram_w_mask;
    logic [63:0] ram_w_data;
    logic [63:0] ram_r_data;
    logic        ram_busy;
    logic        ram_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   nbusy;

    data_ram_resp dut (
        .clk        (clk),
        .rst        (rst),
        .ram_addr   (ram_addr),
        .ram_r_ena  (ram_r_ena),
        .ram_w_ena  (ram_w_ena),
        .ram_w_mask (ram_w_mask),
        .ram_w_data (ram_w_data),
        .ram_r_data (ram_r_data),
        .ram_busy   (ram_busy),
        .ram_err    (ram_err),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [63:0] data);
        exp_t e;
        e.name = name;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drive one access for one cycle; it is sampled at the next rising edge.
    task automatic acc(input logic r, input logic w, input logic [63:0] a,
                       input logic [63:0] m, input logic [63:0] d);
        ram_r_ena  = r;
        ram_w_ena  = w;
        ram_addr   = a;
        ram_w_mask = m;
        ram_w_data = d;
        step();
        ram_r_ena  = 1'b0;
        ram_w_ena  = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!ram_busy) break;
            if (i == 0) chk("rdata_while_busy", ram_r_data, 64'h0);
            n++;
        end
    endtask

    // Monitor: every serviced read presented by the DUT consumes one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_r_ena && !ram_busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_read: got %h, expected no read", ram_r_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(e.name, ram_r_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        ram_addr   = BASE;
        ram_r_ena  = 1'b1;
        ram_w_ena  = 1'b0;
        ram_w_mask = 64'h0;
        ram_w_data = 64'h0;
        step();
        step();
        chk("reset_busy", {63'h0, ram_busy}, 64'h1);
        chk("reset_rdata", ram_r_data, 64'h0);
        chk("reset_err", {63'h0, ram_err}, 64'h0);
        chk("reset_rd_cnt", {32'h0, rd_cnt}, 64'h0);
        chk("reset_wr_cnt", {32'h0, wr_cnt}, 64'h0);

        // Clear with a read held at BASE the whole time.
        push("first_read_after_clear", 64'h0);
        rst = 1'b0;
        count_busy(nbusy);
        chk("clear_busy_cycles", 64'(nbusy), 64'd256);
        chk("clear_err", {63'h0, ram_err}, 64'h1);
        chk("clear_rd_cnt", {32'h0, rd_cnt}, 64'h0);
        step();
        ram_r_ena = 1'b0;

        // Masked partial overwrite.
        acc(1'b0, 1'b1, BASE + 64'd8, ONES, 64'h1122_3344_5566_7788);
        acc(1'b0, 1'b1, BASE + 64'd8, 64'h0000_0000_0000_FF00, 64'h0000_0000_0000_AA00);
        push("masked_merge", 64'h1122_3344_5566_AA88);
        acc(1'b1, 1'b0, BASE + 64'd8, 64'h0, 64'h0);
        chk("wr_cnt_two", {32'h0, wr_cnt}, 64'd2);

        // Same-cycle read and write: old word first, new word next cycle.
        push("rw_same_cycle_old", 64'h0);
        acc(1'b1, 1'b1, BASE + 64'd16, ONES, 64'h0000_0000_DEAD_BEEF);
        push("rw_next_cycle_new", 64'h0000_0000_DEAD_BEEF);
        acc(1'b1, 1'b0, BASE + 64'd16, 64'h0, 64'h0);
        chk("rd_cnt_four", {32'h0, rd_cnt}, 64'd4);
        chk("wr_cnt_three", {32'h0, wr_cnt}, 64'd3);

        // Reset at clear cycle 100 restarts the clear.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(nbusy);
        chk("restart_busy_cycles", 64'(nbusy), 64'd256);
        chk("restart_err", {63'h0, ram_err}, 64'h0);
        chk("restart_rd_cnt", {32'h0, rd_cnt}, 64'h0);
        chk("restart_wr_cnt", {32'h0, wr_cnt}, 64'h0);
        step();

        push("cleared_word", 64'h0);
        acc(1'b1, 1'b0, BASE + 64'd8, 64'h0, 64'h0);
        acc(1'b0, 1'b1, BASE + 64'd2040, ONES, 64'hA5A5_5A5A_0F0F_F0F0);
        push("last_entry", 64'hA5A5_5A5A_0F0F_F0F0);
        acc(1'b1, 1'b0, BASE + 64'd2040, 64'h0, 64'h0);
        acc(1'b0, 1'b1, BASE + 64'd2040, 64'h0, 64'h0);
        push("zero_mask_unchanged", 64'hA5A5_5A5A_0F0F_F0F0);
        acc(1'b1, 1'b0, BASE + 64'd2040, 64'h0, 64'h0);
        chk("inrange_err", {63'h0, ram_err}, 64'h0);
        chk("zero_mask_wr_cnt", {32'h0, wr_cnt}, 64'd2);

        // Out-of-range accesses just past the top and just below the base.
        acc(1'b0, 1'b1, BASE + 64'd2048, ONES, ONES);
        acc(1'b0, 1'b1, BASE - 64'd8, ONES, ONES);
        push("oor_read_top", 64'h0);
        acc(1'b1, 1'b0, BASE + 64'd2048, 64'h0, 64'h0);
        push("oor_read_below", 64'h0);
        acc(1'b1, 1'b0, BASE - 64'd8, 64'h0, 64'h0);
        chk("oor_err", {63'h0, ram_err}, 64'h1);
        chk("oor_rd_cnt", {32'h0, rd_cnt}, 64'd3);
        chk("oor_wr_cnt", {32'h0, wr_cnt}, 64'd2);
        push("oor_no_alias_entry0", 64'h0);
        acc(1'b1, 1'b0, BASE, 64'h0, 64'h0);
        push("oor_no_alias_entry255", 64'hA5A5_5A5A_0F0F_F0F0);
        acc(1'b1, 1'b0, BASE + 64'd2040, 64'h0, 64'h0);

        // Read counter saturation.
        force dut.rd_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.rd_cnt_q;
        push("sat_read0", 64'h0);
        acc(1'b1, 1'b0, BASE, 64'h0, 64'h0);
        chk("sat_rd_cnt_one", {32'h0, rd_cnt}, 64'h0000_0000_FFFF_FFFF);
        push("sat_read1", 64'h0);
        acc(1'b1, 1'b0, BASE, 64'h0, 64'h0);
        push("sat_read2", 64'h0);
        acc(1'b1, 1'b0, BASE, 64'h0, 64'h0);
        chk("sat_rd_cnt_three", {32'h0, rd_cnt}, 64'h0000_0000_FFFF_FFFF);

        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
